// File: rtl/oled_value_bcd.sv
// Converts four binary display values to packed BCD with one shared
// double-dabble engine; the four results are published together on done_out.
module oled_value_bcd #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [BIN_W-1:0]      fre_in,
  input  logic [BIN_W-1:0]      am_in,
  input  logic [BIN_W-1:0]      phase_in,
  input  logic [BIN_W-1:0]      smg_in,
  input  logic                  refresh_in,
  output logic [4*DIGITS-1:0]   fre_bcd_out,
  output logic [4*DIGITS-1:0]   am_bcd_out,
  output logic [4*DIGITS-1:0]   phase_bcd_out,
  output logic [4*DIGITS-1:0]   smg_bcd_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [BIN_W-1:0]  snap [4];
  logic [BCD_W-1:0]  work [4];
  logic              pending;
  logic [1:0]        ch;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic [BIN_W-1:0]  snap_sel;
  logic              trigger;

  assign trigger = pending | refresh_in |
                   (fre_in   != snap[0]) | (am_in  != snap[1]) |
                   (phase_in != snap[2]) | (smg_in != snap[3]);

  always_comb begin
    snap_sel = snap[ch];
  end

  // Add-3 correction on each BCD digit, then one left shift of {BCD, BIN}.
  always_comb begin
    sr_adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W + 4*d +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      pending       <= 1'b1;
      ch            <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      fre_bcd_out   <= '0;
      am_bcd_out    <= '0;
      phase_bcd_out <= '0;
      smg_bcd_out   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        snap[i] <= '0;
        work[i] <= '0;
      end
    end else begin
      done_out <= 1'b0;
      if (state != S_IDLE && refresh_in)
        pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            snap[0]  <= fre_in;
            snap[1]  <= am_in;
            snap[2]  <= phase_in;
            snap[3]  <= smg_in;
            pending  <= 1'b0;
            ch       <= '0;
            busy_out <= 1'b1;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          sr      <= SR_W'(snap_sel);
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          sr      <= sr_shift;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(BIN_W - 1))
            state <= S_STORE;
        end
        S_STORE: begin
          work[ch] <= sr[SR_W-1 -: BCD_W];
          // busy drops on entry to DONE so it covers only the conversion cycles
          if (ch == 2'd3) begin
            busy_out <= 1'b0;
            state    <= S_DONE;
          end else begin
            ch    <= ch + 2'd1;
            state <= S_PREP;
          end
        end
        S_DONE: begin
          fre_bcd_out   <= work[0];
          am_bcd_out    <= work[1];
          phase_bcd_out <= work[2];
          smg_bcd_out   <= work[3];
          done_out      <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_value_bcd.sv
// Directed and table-driven checks of the four-channel binary-to-BCD converter.
module tb_oled_value_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] fre, am, phase, smg;
  logic        refresh;
  logic [27:0] fre_bcd, am_bcd, phase_bcd, smg_bcd;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  oled_value_bcd #(.BIN_W(20), .DIGITS(7)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .fre_in        (fre),
    .am_in         (am),
    .phase_in      (phase),
    .smg_in        (smg),
    .refresh_in    (refresh),
    .fre_bcd_out   (fre_bcd),
    .am_bcd_out    (am_bcd),
    .phase_bcd_out (phase_bcd),
    .smg_bcd_out   (smg_bcd),
    .busy_out      (busy),
    .done_out      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] fre, am, ph, smg;
    logic [27:0] ef, ea, ep, es;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [27:0] to_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [27:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 7; i++)
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < limit && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic apply(input logic [19:0] f, a, p, s);
    @(negedge clk);
    fre = f; am = a; phase = p; smg = s;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [19:0] f, a, p, s,
                         input logic [27:0] ef, ea, ep, es);
    int c;
    bit ok;
    apply(f, a, p, s);
    wait_done(200, c, ok);
    chk_int({tag, "_done_seen"}, int'(ok), 1);
    chk({tag, "_fre"}, fre_bcd, ef);
    chk({tag, "_am"}, am_bcd, ea);
    chk({tag, "_phase"}, phase_bcd, ep);
    chk({tag, "_smg"}, smg_bcd, es);
  endtask

  initial begin
    int  c, c2, dc, bcnt, dones;
    bit  ok, ok2;
    logic [19:0] rf, ra, rp, rs;
    logic [27:0] hold_f;

    vecs[0] = '{20'd686009, 20'd456, 20'd0, 20'd123456,
                28'h0686009, 28'h0000456, 28'h0000000, 28'h0123456};
    vecs[1] = '{20'd1048575, 20'd1048575, 20'd1048575, 20'd1048575,
                28'h1048575, 28'h1048575, 28'h1048575, 28'h1048575};
    vecs[2] = '{20'd0, 20'd0, 20'd0, 20'd0,
                28'h0000000, 28'h0000000, 28'h0000000, 28'h0000000};
    vecs[3] = '{20'd999999, 20'd9, 20'd10, 20'd99,
                28'h0999999, 28'h0000009, 28'h0000010, 28'h0000099};
    vecs[4] = '{20'd500000, 20'd55555, 20'd1000000, 20'd7,
                28'h0500000, 28'h0055555, 28'h1000000, 28'h0000007};
    vecs[5] = '{20'd1, 20'd100, 20'd65535, 20'd524288,
                28'h0000001, 28'h0000100, 28'h0065535, 28'h0524288};
    vecs[6] = '{20'd888888, 20'd1048574, 20'd50, 20'd12345,
                28'h0888888, 28'h1048574, 28'h0000050, 28'h0012345};

    // Reset state and first pass after release
    rst_n = 1'b0; refresh = 1'b0;
    fre = 20'd686009; am = 20'd456; phase = 20'd0; smg = 20'd123456;
    repeat (3) @(negedge clk);
    chk("rst_fre", fre_bcd, '0);
    chk("rst_am", am_bcd, '0);
    chk("rst_phase", phase_bcd, '0);
    chk("rst_smg", smg_bcd, '0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    rst_n = 1'b1;
    bcnt = 0; dc = 0;
    for (int cyc = 1; cyc <= 200 && dc == 0; cyc++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) dc = cyc;
    end
    chk_int("first_latency", dc - 1, 89);
    chk_int("first_busy_cycles", bcnt, 88);
    chk("first_fre", fre_bcd, 28'h0686009);
    chk("first_am", am_bcd, 28'h0000456);
    chk("first_phase", phase_bcd, 28'h0000000);
    chk("first_smg", smg_bcd, 28'h0123456);
    @(posedge clk); #1;
    chk_int("done_one_cycle", int'(done), 0);

    // Steady inputs: no further passes
    dones = 0; bcnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) bcnt++;
    end
    chk_int("steady_dones", dones, 0);
    chk_int("steady_busy", bcnt, 0);

    // Single refresh pulse: one pass, same outputs
    @(negedge clk); refresh = 1'b1;
    @(negedge clk); refresh = 1'b0;
    dones = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk_int("refresh_dones", dones, 1);
    chk("refresh_fre", fre_bcd, 28'h0686009);
    chk("refresh_smg", smg_bcd, 28'h0123456);

    // Table vectors
    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].fre, vecs[i].am, vecs[i].ph, vecs[i].smg,
              vecs[i].ef, vecs[i].ea, vecs[i].ep, vecs[i].es);

    // Input change mid-pass: first result from snapshot, retrigger right after
    @(negedge clk); fre = 20'd975633;
    repeat (30) @(negedge clk);
    fre = 20'd25081;
    wait_done(200, c, ok);
    chk_int("chg_done1_seen", int'(ok), 1);
    chk("chg_fre1", fre_bcd, 28'h0975633);
    wait_done(200, c2, ok2);
    chk_int("chg_done2_seen", int'(ok2), 1);
    chk_int("chg_gap", c2, 90);
    chk("chg_fre2", fre_bcd, 28'h0025081);

    // Several refresh pulses during one pass: exactly one extra pass
    @(negedge clk); refresh = 1'b1;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      refresh = (i == 10 || i == 20 || i == 40);
    end
    refresh = 1'b0;
    chk_int("multi_refresh_dones", dones, 2);

    // Simultaneous change and refresh in IDLE: one pass
    @(negedge clk); fre = 20'd314159; refresh = 1'b1;
    @(negedge clk); refresh = 1'b0;
    dones = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk_int("chg_refresh_dones", dones, 1);
    chk("chg_refresh_fre", fre_bcd, 28'h0314159);

    // Reset at cycle 50 of a pass
    hold_f = fre_bcd;
    apply(20'd123, 20'd4567, 20'd89012, 20'd345678);
    repeat (49) @(negedge clk);
    chk("midpass_outputs_stable", fre_bcd, hold_f);
    rst_n = 1'b0;
    #1;
    chk("midrst_fre", fre_bcd, '0);
    chk("midrst_am", am_bcd, '0);
    chk("midrst_phase", phase_bcd, '0);
    chk("midrst_smg", smg_bcd, '0);
    chk_int("midrst_busy", int'(busy), 0);
    chk_int("midrst_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_done(200, c, ok);
    chk_int("postrst_done_seen", int'(ok), 1);
    chk_int("postrst_latency", c, 90);
    chk("postrst_fre", fre_bcd, 28'h0000123);
    chk("postrst_am", am_bcd, 28'h0004567);
    chk("postrst_phase", phase_bcd, 28'h0089012);
    chk("postrst_smg", smg_bcd, 28'h0345678);

    // Random sweep against an integer-to-decimal model
    for (int i = 0; i < 300; i++) begin
      rf = 20'($urandom_range(0, 1048575));
      ra = 20'($urandom_range(0, 1048575));
      rp = 20'($urandom_range(0, 1048575));
      rs = 20'($urandom_range(0, 1048575));
      run_vec($sformatf("rnd%0d", i), rf, ra, rp, rs,
              to_bcd(rf), to_bcd(ra), to_bcd(rp), to_bcd(rs));
      chk_int($sformatf("rnd%0d_digits", i),
              int'(digits_ok(fre_bcd) && digits_ok(am_bcd) &&
                   digits_ok(phase_bcd) && digits_ok(smg_bcd)), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
